// File: rtl/l2_l1_responder.sv
// ============================================================================
// Module   : l2_l1_responder
// Brief    : L2-side responder for the L1<->L2 read/write protocol, backed by
//            a 64-bit word store and answering with an active-low strobe.
//            Optional misalignment checking is enabled by L2_ALIGN_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_l1_responder #(
    parameter int INDEX_BITS = 6,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr_in,
    inout  wire  [63:0] data_inout,
    output logic        stb,
    output logic        busy,
    output logic        err
);

    localparam int         c_DEPTH     = 2 ** INDEX_BITS;
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT      = 2'd1;
    localparam logic [1:0] c_STRB      = 2'd2;
    localparam logic       c_ZERO_LAT  = (LATENCY == 0);
    localparam logic [3:0] c_WAIT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [INDEX_BITS-1:0] r_idx;
    logic                  r_we;
    logic                  r_mis;
    logic [63:0]           r_rdata;
    logic [63:0]           r_mem [c_DEPTH];
    logic [c_DEPTH-1:0]    r_valid;

    logic                  w_acc;
    logic [INDEX_BITS-1:0] w_idx_in;
    logic                  w_mis_in;
    logic                  w_cur_we;
    logic                  w_cur_mis;
    logic [INDEX_BITS-1:0] w_cur_idx;
    logic                  w_enter_strb;
    logic                  w_mem_wr;
    logic                  w_oe;
    logic [63:0]           w_rdata_in;

`ifdef L2_ALIGN_CHK_EN
    assign w_mis_in = |addr_in[2:0];
`else
    assign w_mis_in = 1'b0;
`endif

    assign w_acc    = (r_state == c_IDLE) && req;
    assign w_idx_in = addr_in[INDEX_BITS+2:3];

    // With zero latency the store update lands on the accept edge itself,
    // so the write target must come straight from the inputs.
    assign w_cur_we     = (r_state == c_IDLE) ? we       : r_we;
    assign w_cur_mis    = (r_state == c_IDLE) ? w_mis_in : r_mis;
    assign w_cur_idx    = (r_state == c_IDLE) ? w_idx_in : r_idx;
    assign w_enter_strb = ((r_state == c_WAIT) && (r_cnt == 4'd0)) || (w_acc && c_ZERO_LAT);
    assign w_mem_wr     = rst_n && w_enter_strb && !w_cur_we && !w_cur_mis;

    always_comb begin
        w_rdata_in = {32'h0, addr_in};
        if (w_mis_in) begin
            w_rdata_in = 64'h0;
        end else if (r_valid[w_idx_in]) begin
            w_rdata_in = r_mem[w_idx_in];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_we    <= 1'b1;
            r_mis   <= 1'b0;
            r_rdata <= 64'h0;
            r_valid <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req) begin
                        r_idx   <= w_idx_in;
                        r_we    <= we;
                        r_mis   <= w_mis_in;
                        r_cnt   <= c_WAIT_LOAD;
                        r_rdata <= w_rdata_in;
                        r_state <= c_ZERO_LAT ? c_STRB : c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_STRB;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_STRB:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
            if (w_mem_wr) begin
                r_valid[w_cur_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            r_mem[w_cur_idx] <= data_inout;
        end
    end

    assign busy       = (r_state != c_IDLE);
    assign stb        = (r_state != c_STRB);
    assign err        = (r_state == c_STRB) && r_mis;
    assign w_oe       = busy && r_we;
    assign data_inout = w_oe ? r_rdata : 64'hz;

endmodule

`default_nettype wire

// File: tb/tb_l2_l1_responder.sv
// ============================================================================
// Module   : tb_l2_l1_responder
// Brief    : Self-checking bench for l2_l1_responder against a word-store model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_l1_responder;

    localparam int INDEX_BITS = 6;
    localparam int LATENCY    = 2;
    localparam int DEPTH      = 2 ** INDEX_BITS;
`ifdef L2_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [31:0] addr_in;
    wire  [63:0] data_inout;
    logic        stb;
    logic        busy;
    logic        err;
    logic        tb_oe;
    logic [63:0] tb_drv;

    int checks = 0;
    int errors = 0;

    logic [63:0] ref_mem [DEPTH];
    bit          ref_val [DEPTH];

    assign data_inout = tb_oe ? tb_drv : 64'hz;

    always #5 clk = ~clk;

    l2_l1_responder #(.INDEX_BITS(INDEX_BITS), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .we         (we),
        .addr_in    (addr_in),
        .data_inout (data_inout),
        .stb        (stb),
        .busy       (busy),
        .err        (err)
    );

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[INDEX_BITS+2:3]);
    endfunction

    function automatic logic [63:0] model_read(input logic [31:0] a);
        if (ALIGN && (a[2:0] != 3'b0)) return 64'h0;
        if (ref_val[idx_of(a)]) return ref_mem[idx_of(a)];
        return {32'h0, a};
    endfunction

    // One complete request; checks timing, bus window, strobe and release.
    task automatic do_txn(input logic [31:0] a, input logic rd, input logic [63:0] wd);
        logic [63:0] exp;
        bit          mis;
        int          k;
        mis = ALIGN && (a[2:0] != 3'b0);
        exp = model_read(a);
        req = 1'b1; we = rd; addr_in = a; tb_oe = !rd; tb_drv = wd;
        @(posedge clk); #1;
        req = 1'b0; addr_in = $urandom; we = 1'($urandom);
        k = 0;
        while (stb !== 1'b0 && k < 20) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL busy_wait: got %b want 1 (addr %h)", busy, a);
            end
            checks++;
            if (rd && data_inout !== exp) begin
                errors++; $display("FAIL rd_window: got %h want %h (addr %h)", data_inout, exp, a);
            end else if (!rd && data_inout !== wd) begin
                errors++; $display("FAIL wr_bus: got %h want %h (addr %h)", data_inout, wd, a);
            end
            @(posedge clk); #1; k++;
        end
        checks++;
        if (k != LATENCY) begin
            errors++; $display("FAIL latency: got %0d cycles want %0d (addr %h)", k + 1, LATENCY + 1, a);
        end
        if (stb === 1'b0) begin
            if (rd) begin
                checks++;
                if (data_inout !== exp) begin
                    errors++; $display("FAIL rd_data: got %h want %h (addr %h)", data_inout, exp, a);
                end
            end
            checks++;
            if (err !== mis) begin
                errors++; $display("FAIL err_strb: got %b want %b (addr %h)", err, mis, a);
            end
        end
        tb_oe = 1'b0;
        if (!rd && !mis) begin
            ref_mem[idx_of(a)] = wd;
            ref_val[idx_of(a)] = 1'b1;
        end
        @(posedge clk); #1;
        checks++;
        if (stb !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL idle_after: got stb=%b busy=%b err=%b want 1 0 0", stb, busy, err);
        end
        tb_oe = 1'b1; tb_drv = 64'h0;
        #1;
        checks++;
        if (data_inout !== 64'h0) begin
            errors++; $display("FAIL bus_release: got %h want %h", data_inout, 64'h0);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 1'b0; we = 1'b1; addr_in = '0; tb_oe = 1'b1; tb_drv = 64'h0;
        for (int i = 0; i < DEPTH; i++) ref_val[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (stb !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || data_inout !== 64'h0) begin
            errors++;
            $display("FAIL reset: got stb=%b busy=%b err=%b bus=%h want 1 0 0 0", stb, busy, err, data_inout);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_unwritten;
        do_txn(32'h0000_0040, 1'b1, 64'h0);
    endtask

    task automatic test_write_alias;
        do_txn(32'h0000_0048, 1'b0, 64'hDEAD_BEEF_0000_0001);
        do_txn(32'h0000_0048, 1'b1, 64'h0);
        do_txn(32'h0000_0248, 1'b1, 64'h0);
    endtask

    task automatic test_back_to_back;
        logic [63:0] got_mask;
        logic [63:0] exp_mask;
        logic [63:0] exp;
        int          n;
        n = 3 * (LATENCY + 2);
        exp = model_read(32'h0000_0048);
        got_mask = '0; exp_mask = '0;
        for (int j = 0; j < 3; j++) exp_mask[LATENCY + j * (LATENCY + 2)] = 1'b1;
        req = 1'b1; we = 1'b1; addr_in = 32'h0000_0048; tb_oe = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            if (stb === 1'b0) begin
                got_mask[k] = 1'b1;
                checks++;
                if (data_inout !== exp) begin
                    errors++; $display("FAIL b2b_data: got %h want %h at cycle %0d", data_inout, exp, k);
                end
            end
            if (k == n - 1) req = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (got_mask !== exp_mask) begin
            errors++; $display("FAIL b2b_strobes: got %h want %h", got_mask, exp_mask);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got busy=%b want 0", busy);
        end
        tb_oe = 1'b1; tb_drv = 64'h0;
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic        rd;
        for (int t = 0; t < 40; t++) begin
            a  = $urandom & 32'h0000_0FFF;
            rd = 1'($urandom_range(0, 1));
            do_txn(a, rd, {$urandom, $urandom});
        end
    endtask

    task automatic test_reset_mid_write;
        int strobes;
        req = 1'b1; we = 1'b0; addr_in = 32'h0000_0100; tb_oe = 1'b1; tb_drv = 64'h1234_5678_9ABC_DEF0;
        @(posedge clk); #1;
        req = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (stb !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got stb=%b busy=%b err=%b want 1 0 0", stb, busy, err);
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_val[i] = 1'b0;
        strobes = 0;
        repeat (LATENCY + 3) begin
            @(posedge clk); #1;
            if (stb === 1'b0) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            errors++; $display("FAIL aborted_strobe: got %0d strobes want 0", strobes);
        end
        tb_drv = 64'h0;
        do_txn(32'h0000_0100, 1'b1, 64'h0);
    endtask

    task automatic test_align;
        do_txn(32'h0000_0049, 1'b0, 64'hCAFE_F00D_1122_3344);
        do_txn(32'h0000_0048, 1'b1, 64'h0);
        do_txn(32'h0000_004B, 1'b1, 64'h0);
    endtask

    initial begin
        test_reset();
        test_read_unwritten();
        test_write_alias();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        test_align();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
